// File: rtl/div_ctrl.sv
// Multi-cycle RV32M divide controller: 32-step restoring division for DIV/DIVU/REM/REMU,
// with pipeline stall, flush cancellation and a registered write-back result.
module div_ctrl #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [XLEN-1:0]   divisor_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic              reg_wr_en_o,
  output logic [REG_AW-1:0] reg_wr_adder_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [4:0]        r_count;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_divisor;
  logic [1:0]        r_op;
  logic              r_dividendNeg;
  logic              r_divisorNeg;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_result;
  logic [REG_AW-1:0] r_rdOut;

  logic              w_signed;
  logic              w_divZero;
  logic              w_overflow;
  logic [XLEN-1:0]   w_absDividend;
  logic [XLEN-1:0]   w_absDivisor;
  logic [XLEN-1:0]   w_special;
  logic [XLEN:0]     w_shift;
  logic [XLEN+1:0]   w_trial;
  logic              w_trialOk;
  logic [XLEN:0]     w_remNext;
  logic [XLEN-1:0]   w_quoNext;
  logic [XLEN-1:0]   w_quoFinal;
  logic [XLEN-1:0]   w_remFinal;

  // Request-side decode: magnitudes for the datapath and the short-circuit results.
  assign w_signed      = ~op_i[0];
  assign w_divZero     = (divisor_i == '0);
  assign w_overflow    = w_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
  assign w_absDividend = (w_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign w_absDivisor  = (w_signed && divisor_i[XLEN-1]) ? -divisor_i : divisor_i;
  assign w_special     = w_divZero ? (op_i[1] ? dividend_i : '1)
                                   : (op_i[1] ? '0 : MIN_NEG);

  // One restoring step; the extra top bit of the trial is its sign.
  assign w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_trial    = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_trialOk  = ~w_trial[XLEN+1];
  assign w_remNext  = w_trialOk ? w_trial[XLEN:0] : w_shift;
  assign w_quoNext  = {r_quo[XLEN-2:0], w_trialOk};
  assign w_quoFinal = (~r_op[0] && (r_dividendNeg ^ r_divisorNeg)) ? -w_quoNext : w_quoNext;
  assign w_remFinal = (~r_op[0] && r_dividendNeg) ? -w_remNext[XLEN-1:0] : w_remNext[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_divisor     <= '0;
      r_op          <= '0;
      r_dividendNeg <= 1'b0;
      r_divisorNeg  <= 1'b0;
      r_rd          <= '0;
      r_result      <= '0;
      r_rdOut       <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_op          <= op_i;
            r_rd          <= rd_i;
            r_dividendNeg <= w_signed & dividend_i[XLEN-1];
            r_divisorNeg  <= w_signed & divisor_i[XLEN-1];
            if (w_divZero || w_overflow) begin
              r_result <= w_special;
              r_rdOut  <= rd_i;
              r_state  <= ST_DONE;
            end else begin
              r_quo     <= w_absDividend;
              r_divisor <= w_absDivisor;
              r_rem     <= '0;
              r_count   <= '0;
              r_state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_result <= r_op[1] ? w_remFinal : w_quoFinal;
            r_rdOut  <= r_rd;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o         = (r_state != ST_IDLE);
  assign stall_o        = ((r_state == ST_IDLE) && start_i && !flush_i) || (r_state == ST_CALC);
  assign valid_o        = (r_state == ST_DONE) && !flush_i;
  assign reg_wr_en_o    = valid_o;
  assign result_o       = r_result;
  assign reg_wr_adder_o = r_rdOut;

endmodule
